// File: rtl/nibble_serial_add_ctrl_if.sv
// Handshake, operand/result and 4-bit slice signals of the nibble-serial adder controller.
// The slave modport is the controller; the master is the user logic plus the external slice.
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             CO;
  logic [3:0]       slice_A;
  logic [3:0]       slice_B;
  logic             slice_cin;
  logic [3:0]       slice_Sum;
  logic             slice_CO;

  modport master (
    output start, A, B, c_in, slice_Sum, slice_CO,
    input  busy, done, Sum, CO, slice_A, slice_B, slice_cin
  );

  modport slave (
    input  start, A, B, c_in, slice_Sum, slice_CO,
    output busy, done, Sum, CO, slice_A, slice_B, slice_cin
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Adds two WIDTH-bit operands one nibble per clock through an external 4-bit slice; result after NIB+1 edges.
// No backpressure: start is taken only in IDLE, ignored (not queued) in RUN/DONE; done is a one-cycle pulse.
module nibble_serial_add_ctrl #(
  parameter  int WIDTH = 16,
  localparam int NIB   = WIDTH / 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  nibble_serial_add_ctrl_if.slave bus
);

  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                carry_r;
  logic [NIB-1:0][3:0] a_r;
  logic [NIB-1:0][3:0] b_r;
  logic [NIB-1:0][3:0] part_r;
  logic [NIB-1:0][3:0] fin;
  logic [WIDTH-1:0]    sum_r;
  logic                co_r;
  logic                last_nib;

  assign last_nib = (cnt == CW'(NIB - 1));

  // Final result merges the last slice nibble directly, so Sum is ready on entry to DONE.
  always_comb begin
    fin          = part_r;
    fin[NIB-1]   = bus.slice_Sum;
  end

  always_comb begin
    bus.slice_A   = 4'd0;
    bus.slice_B   = 4'd0;
    bus.slice_cin = 1'b0;
    if (state == RUN) begin
      bus.slice_cin = carry_r;
      for (int i = 0; i < NIB; i++) begin
        if (cnt == CW'(i)) begin
          bus.slice_A = a_r[i];
          bus.slice_B = b_r[i];
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      part_r  <= '0;
      sum_r   <= '0;
      co_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r     <= bus.A;
            b_r     <= bus.B;
            carry_r <= bus.c_in;
            cnt     <= '0;
            part_r  <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (cnt == CW'(i)) begin
              part_r[i] <= bus.slice_Sum;
            end
          end
          carry_r <= bus.slice_CO;
          cnt     <= cnt + 1'b1;
          if (last_nib) begin
            sum_r <= fin;
            co_r  <= bus.slice_CO;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.Sum  = sum_r;
  assign bus.CO   = co_r;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl at WIDTH=16 with a behavioural 4-bit slice.
module tb_nibble_serial_add_ctrl;
  localparam int WIDTH = 16;

  logic Clk = 1'b0;
  logic Reset;
  int   n_asserts = 0;
  int   n_fail    = 0;
  logic [15:0] prev_sum;
  logic        prev_co;

  nibble_serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  assign {bus.slice_CO, bus.slice_Sum} = {1'b0, bus.slice_A} + {1'b0, bus.slice_B} + {4'b0, bus.slice_cin};

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic [15:0] esum, input logic eco, input logic [3:0] ecin);
    bus.A     = a;
    bus.B     = b;
    bus.c_in  = cin;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
    bus.c_in  = ~cin;
    for (int i = 0; i < 4; i++) begin
      chk("busy_run", bus.busy, 1);
      chk("done_run", bus.done, 0);
      chk("slice_A", bus.slice_A, a[4*i +: 4]);
      chk("slice_B", bus.slice_B, b[4*i +: 4]);
      chk("slice_cin", bus.slice_cin, ecin[i]);
      chk("sum_hold", bus.Sum, prev_sum);
      chk("co_hold", bus.CO, prev_co);
      tick;
    end
    chk("done_pulse", bus.done, 1);
    chk("busy_done", bus.busy, 0);
    chk("sum", bus.Sum, esum);
    chk("co", bus.CO, eco);
    chk("slice_A_done", bus.slice_A, 0);
    chk("slice_cin_done", bus.slice_cin, 0);
    prev_sum = esum;
    prev_co  = eco;
    tick;
    chk("done_after", bus.done, 0);
    chk("busy_after", bus.busy, 0);
    chk("sum_after", bus.Sum, esum);
  endtask

  initial begin
    Reset     = 1'b1;
    bus.start = 1'b0;
    bus.A     = 16'h0;
    bus.B     = 16'h0;
    bus.c_in  = 1'b0;
    prev_sum  = 16'h0;
    prev_co   = 1'b0;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.Sum, 0);
    chk("rst_co", bus.CO, 0);
    chk("rst_slice_A", bus.slice_A, 0);
    @(negedge Clk);
    Reset = 1'b0;
    tick;
    tick;
    chk("idle_no_start", bus.busy, 0);

    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 4'b0000);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 4'b1110);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b1110);
    run_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'b1111);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 4'b0000);

    // start held high; operands change mid-operation
    bus.A     = 16'h0001;
    bus.B     = 16'h0001;
    bus.c_in  = 1'b0;
    bus.start = 1'b1;
    tick;
    chk("hold_E0_busy", bus.busy, 1);
    tick;
    tick;
    bus.A = 16'h0002;
    bus.B = 16'h0002;
    tick;
    chk("hold_E3_busy", bus.busy, 1);
    chk("hold_E3_slice_A", bus.slice_A, 0);
    tick;
    chk("hold_E4_done", bus.done, 1);
    chk("hold_first_sum", bus.Sum, 16'h0002);
    chk("hold_first_co", bus.CO, 0);
    tick;
    chk("hold_E5_busy", bus.busy, 0);
    chk("hold_E5_done", bus.done, 0);
    tick;
    chk("hold_E6_busy", bus.busy, 1);
    chk("hold_E6_slice_A", bus.slice_A, 2);
    bus.start = 1'b0;
    tick;
    tick;
    tick;
    chk("hold_E9_sum", bus.Sum, 16'h0002);
    tick;
    chk("hold_E10_done", bus.done, 1);
    chk("hold_second_sum", bus.Sum, 16'h0004);
    tick;
    prev_sum = 16'h0004;
    prev_co  = 1'b0;

    // reset in the middle of an operation
    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 4'b0000);
    bus.A     = 16'h0F0F;
    bus.B     = 16'h00F1;
    bus.c_in  = 1'b0;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    tick;
    chk("mid_busy", bus.busy, 1);
    #2;
    Reset = 1'b1;
    #1;
    chk("mrst_sum", bus.Sum, 0);
    chk("mrst_co", bus.CO, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_done", bus.done, 0);
    chk("mrst_slice_A", bus.slice_A, 0);
    chk("mrst_slice_B", bus.slice_B, 0);
    chk("mrst_slice_cin", bus.slice_cin, 0);
    tick;
    @(negedge Clk);
    Reset = 1'b0;
    tick;
    chk("post_rst_done", bus.done, 0);
    tick;
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_done2", bus.done, 0);
    prev_sum = 16'h0000;
    prev_co  = 1'b0;
    run_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 4'b1110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
